// File: rtl/r_arbiter.sv
// Round-robin arbiter that merges several AXI R-channel FIFOs onto one master R port.
// A granted FIFO owns the channel for a whole burst; the output beat sits in a register slice.
module r_arbiter #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVE  = 3
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic [NUM_SLAVE-1:0]            s_empty,
    input  logic [NUM_SLAVE*ID_WIDTH-1:0]   s_RID,
    input  logic [NUM_SLAVE*DATA_WIDTH-1:0] s_RDATA,
    input  logic [NUM_SLAVE*2-1:0]          s_RRESP,
    input  logic [NUM_SLAVE-1:0]            s_RLAST,
    output logic [NUM_SLAVE-1:0]            s_pop,
    output logic [ID_WIDTH-1:0]             RID,
    output logic [DATA_WIDTH-1:0]           RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RLAST,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic [$clog2(NUM_SLAVE)-1:0]    grant,
    output logic                            busy
);

    localparam int GW = $clog2(NUM_SLAVE);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [GW-1:0]         r_grant;
    logic [GW-1:0]         r_rr_ptr;
    logic [GW-1:0]         w_pick;
    logic                  w_found;
    logic                  w_any_req;
    logic                  w_pop;
    logic                  r_busy;
    logic                  r_rvalid;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_rlast;
    logic                  w_sel_empty;
    logic [ID_WIDTH-1:0]   w_sel_id;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [1:0]            w_sel_resp;
    logic                  w_sel_last;

    // Front of the currently granted FIFO.
    always_comb begin
        w_sel_empty = 1'b1;
        w_sel_id    = '0;
        w_sel_data  = '0;
        w_sel_resp  = '0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < NUM_SLAVE; i++) begin
            if (r_grant == GW'(i)) begin
                w_sel_empty = s_empty[i];
                w_sel_id    = s_RID[i*ID_WIDTH +: ID_WIDTH];
                w_sel_data  = s_RDATA[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_resp  = s_RRESP[i*2 +: 2];
                w_sel_last  = s_RLAST[i];
            end
        end
    end

    // First non-empty FIFO at distance 1..NUM_SLAVE after the last winner.
    always_comb begin
        w_pick    = '0;
        w_found   = 1'b0;
        w_any_req = |(~s_empty);
        for (int k = 1; k <= NUM_SLAVE; k++) begin
            for (int j = 0; j < NUM_SLAVE; j++) begin
                if (!w_found && !s_empty[j] && ((int'(r_rr_ptr) + k) % NUM_SLAVE == j)) begin
                    w_pick  = GW'(j);
                    w_found = 1'b1;
                end
            end
        end
    end

    // Master side: a beat transfers on RVALID && RREADY; the slice accepts a new
    // beat whenever it is empty or being drained in the same cycle.
    assign w_pop = (r_state == ST_BURST) && !w_sel_empty && (!r_rvalid || RREADY);

    always_comb begin
        s_pop = '0;
        for (int i = 0; i < NUM_SLAVE; i++) begin
            if (w_pop && (r_grant == GW'(i))) begin
                s_pop[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_req)            w_state_nxt = ST_BURST;
            ST_BURST: if (w_pop && w_sel_last)  w_state_nxt = ST_IDLE;
            default:                            w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_grant  <= '0;
            r_rr_ptr <= GW'(NUM_SLAVE - 1);
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_BURST);
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_grant  <= w_pick;
                r_rr_ptr <= w_pick;
            end
        end
    end

    // Output slice; the last beat drains here while the FSM already re-arbitrates.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rvalid <= 1'b0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= '0;
            r_rlast  <= 1'b0;
        end else if (w_pop) begin
            r_rvalid <= 1'b1;
            r_rid    <= w_sel_id;
            r_rdata  <= w_sel_data;
            r_rresp  <= w_sel_resp;
            r_rlast  <= w_sel_last;
        end else if (RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    assign RVALID = r_rvalid;
    assign RID    = r_rid;
    assign RDATA  = r_rdata;
    assign RRESP  = r_rresp;
    assign RLAST  = r_rlast;
    assign grant  = r_grant;
    assign busy   = r_busy;

endmodule

// File: doc/r_arbiter.md
R_ARBITER -- requirements
Module: r_arbiter

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, meaning RID width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning RDATA width.
REQ-003 SHALL have parameter NUM_SLAVE, default 3, meaning number of upstream R FIFOs arbitrated; legal range 2..8.
REQ-004 SHALL have port clk  input  1  single clock for all state.
REQ-005 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_empty  input  NUM_SLAVE  per-FIFO empty flag; bit i belongs to FIFO i.
REQ-007 SHALL have port s_RID  input  NUM_SLAVE*ID_WIDTH  FIFO fronts; FIFO i at [i*ID_WIDTH +: ID_WIDTH].
REQ-008 SHALL have port s_RDATA  input  NUM_SLAVE*DATA_WIDTH  FIFO fronts; FIFO i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port s_RRESP  input  NUM_SLAVE*2  FIFO fronts; FIFO i at [i*2 +: 2].
REQ-010 SHALL have port s_RLAST  input  NUM_SLAVE  FIFO fronts; bit i belongs to FIFO i.
REQ-011 SHALL have port s_pop  output  NUM_SLAVE  one-cycle pop strobe to FIFO i.
REQ-012 SHALL have ports RID, RDATA, RRESP, RLAST  output  ID_WIDTH/DATA_WIDTH/2/1  master-side AXI R payload.
REQ-013 SHALL have port RVALID  output  1  master-side AXI R valid.
REQ-014 SHALL have port RREADY  input  1  master-side AXI R ready.
REQ-015 SHALL have port grant  output  $clog2(NUM_SLAVE)  index of the FIFO currently owning the channel.
REQ-016 SHALL have port busy  output  1  high while state is BURST.

Function
REQ-017 SHALL implement two states: IDLE and BURST.
REQ-018 In IDLE with any s_empty bit low, SHALL choose the first non-empty FIFO scanning from rr_ptr+1 upward modulo NUM_SLAVE, load grant and rr_ptr with it, and enter BURST next cycle.
REQ-019 In IDLE, s_pop SHALL be all-zero; arbitration costs exactly one cycle.
REQ-020 In BURST, s_pop[grant] SHALL equal ~s_empty[grant] & (~RVALID | RREADY); all other s_pop bits SHALL be 0.
REQ-021 A pop SHALL load that FIFO's front RID/RDATA/RRESP/RLAST into the output register on the same clock edge and set RVALID; latency is 1 cycle from pop to RVALID.
REQ-022 RVALID SHALL clear when RREADY=1 and no pop occurs in that cycle; pop plus RREADY in the same cycle SHALL keep RVALID high with new data (full throughput, one beat per cycle).
REQ-023 While RVALID=1 and RREADY=0, RID/RDATA/RRESP/RLAST SHALL remain stable.
REQ-024 When a popped beat has RLAST=1, the FSM SHALL return to IDLE on that edge; no further pop from that FIFO until re-granted.
REQ-025 The IDLE return SHALL NOT wait for the last beat's master handshake; the output register drains it independently, and a new grant SHALL NOT pop until (~RVALID | RREADY).
REQ-026 Bursts SHALL NOT interleave: once granted, the FIFO keeps the channel until its RLAST beat is popped, regardless of other requests.
REQ-027 An empty granted FIFO mid-burst SHALL stall (no pop, FSM stays BURST) indefinitely.
REQ-028 rr_ptr wrap: after index NUM_SLAVE-1 the scan SHALL continue at 0.
REQ-029 grant and busy SHALL be registered outputs, changing only on clock edges.

Reset
REQ-030 On nrst low, asynchronously: state=IDLE, rr_ptr=NUM_SLAVE-1 (FIFO 0 wins first), grant=0, busy=0, RVALID=0, RID/RDATA/RRESP/RLAST=0.
REQ-031 s_pop SHALL be 0 during reset and in the first cycle after release.
REQ-032 Reset asserted mid-burst SHALL discard the held beat and partial burst; no pop occurs after release until a fresh IDLE arbitration.

Verification
REQ-033 Single burst: FIFO 1 holds 4 beats RID=3, RDATA=0x10..0x13, last on 0x13, RREADY=1 -> grant=1, beats on 4 consecutive cycles starting 2 cycles after empty falls, RLAST with 0x13, busy falls after 4th pop.
REQ-034 Round-robin: FIFOs 0,1,2 each hold one 2-beat burst at reset release -> order 0,1,2; refill all -> order 0,1,2 again; no interleaving.
REQ-035 Backpressure: RREADY low 3 cycles during burst RDATA=0xA5A5A5A5 -> RVALID held, data stable, no pops, zero beats lost or duplicated.
REQ-036 Mid-burst starvation: granted FIFO 2 empties after beat 1 of 3, FIFO 0 non-empty -> FSM stays BURST on 2, no pop from FIFO 0 until FIFO 2 delivers RLAST.
REQ-037 Reset mid-burst: nrst pulse after beat 2 of 4 -> all outputs 0 immediately, next grant goes to lowest non-empty index from 0.
REQ-038 Wrap: only FIFO NUM_SLAVE-1 then FIFO 0 request alternately -> grant sequence 2,0,2,0 (NUM_SLAVE=3).
